// File: rtl/blend_sequencer.sv
// Pixel sequencer between the rasterizer, the alpha blender and the framebuffer SRAM.
// One pixel in flight: opaque pixels skip the read, transparent pixels are dropped.
module blend_sequencer #(
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pixel,
  input  logic [7:0]        in_r,
  input  logic [7:0]        in_g,
  input  logic [7:0]        in_b,
  input  logic [7:0]        in_a,
  input  logic              in_last,
  output logic              bl_pixel_ready,
  output logic [7:0]        bl_r,
  output logic [7:0]        bl_g,
  output logic [7:0]        bl_b,
  output logic [7:0]        bl_a,
  input  logic [7:0]        bl_wr_r,
  input  logic [7:0]        bl_wr_g,
  input  logic [7:0]        bl_wr_b,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_re,
  output logic              fb_we,
  output logic [23:0]       fb_wdata,
  output logic              frame_done,
  output logic [ADDR_W-1:0] frame_px_count
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(RD_LAT - 1);

  state_t            state, state_nxt;
  logic [3:0]        wait_cnt;
  logic              last;
  logic [ADDR_W-1:0] px_cnt;
  logic              accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    in_ready       = 1'b0;
    fb_re          = 1'b0;
    bl_pixel_ready = 1'b0;
    fb_we          = 1'b0;
    frame_done     = 1'b0;
    accept         = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          if (in_a == 8'd0)        state_nxt = in_last ? DONE : IDLE;
          else if (in_a == 8'hFF)  state_nxt = WRITE;
          else                     state_nxt = READ;
        end
      end
      READ: begin
        fb_re          = 1'b1;
        bl_pixel_ready = 1'b1;
        state_nxt      = WAIT;
      end
      WAIT:    if (wait_cnt == '0) state_nxt = WRITE;
      WRITE: begin
        fb_we     = 1'b1;
        state_nxt = last ? DONE : IDLE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fb_addr        <= '0;
      fb_wdata       <= '0;
      bl_r           <= '0;
      bl_g           <= '0;
      bl_b           <= '0;
      bl_a           <= '0;
      last           <= 1'b0;
      wait_cnt       <= '0;
      px_cnt         <= '0;
      frame_px_count <= '0;
    end else begin
      if (accept) begin
        fb_addr <= in_pixel;
        bl_r    <= in_r;
        bl_g    <= in_g;
        bl_b    <= in_b;
        bl_a    <= in_a;
        last    <= in_last;
        if (in_a == 8'hFF) fb_wdata <= {in_r, in_g, in_b};
      end

      if (state == READ)
        wait_cnt <= WAIT_INIT;
      else if (state == WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - 4'd1;

      // Read data is valid on the cycle the counter reaches zero; blender output is combinational.
      if (state == WAIT && wait_cnt == '0)
        fb_wdata <= {bl_wr_r, bl_wr_g, bl_wr_b};

      if (state == WRITE && px_cnt != '1)
        px_cnt <= px_cnt + 1'b1;

      if (state == DONE) begin
        frame_px_count <= px_cnt;
        px_cnt         <= '0;
        last           <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_blend_sequencer.sv
// Self-checking bench for blend_sequencer: latency-modelled SRAM, model blender,
// and a scoreboard of expected framebuffer writes.
module tb_blend_sequencer;

  localparam int unsigned RD_LAT = 2;
  localparam int unsigned ADDR_W = 17;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [23:0]       data;
  } wr_t;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_pixel;
  logic [7:0]        in_r, in_g, in_b, in_a;
  logic              in_last;
  logic              bl_pixel_ready;
  logic [7:0]        bl_r, bl_g, bl_b, bl_a;
  logic [7:0]        bl_wr_r, bl_wr_g, bl_wr_b;
  logic [ADDR_W-1:0] fb_addr;
  logic              fb_re;
  logic              fb_we;
  logic [23:0]       fb_wdata;
  logic              frame_done;
  logic [ADDR_W-1:0] frame_px_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int re_count = 0;
  int we_count = 0;
  int done_count = 0;
  wr_t exp_q[$];

  logic [23:0]       mem [256] = '{default: 24'h0};
  logic [RD_LAT-1:0] pv = '0;
  logic [7:0]        pa [RD_LAT];
  logic [23:0]       fb_rdata;

  blend_sequencer #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_a(in_a), .in_last(in_last),
    .bl_pixel_ready(bl_pixel_ready),
    .bl_r(bl_r), .bl_g(bl_g), .bl_b(bl_b), .bl_a(bl_a),
    .bl_wr_r(bl_wr_r), .bl_wr_g(bl_wr_g), .bl_wr_b(bl_wr_b),
    .fb_addr(fb_addr), .fb_re(fb_re), .fb_we(fb_we), .fb_wdata(fb_wdata),
    .frame_done(frame_done), .frame_px_count(frame_px_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] blend(input logic [7:0] s, input logic [7:0] d, input logic [7:0] a);
    logic [16:0] v;
    v = 17'(s) * 17'(a) + 17'(d) * (17'd256 - 17'(a));
    return v[15:8];
  endfunction

  // SRAM model: data appears RD_LAT cycles after the read strobe, X otherwise.
  assign fb_rdata = pv[RD_LAT-1] ? mem[pa[RD_LAT-1]] : 24'hxxxxxx;
  assign bl_wr_r  = blend(bl_r, fb_rdata[23:16], bl_a);
  assign bl_wr_g  = blend(bl_g, fb_rdata[15:8],  bl_a);
  assign bl_wr_b  = blend(bl_b, fb_rdata[7:0],   bl_a);

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    pv[0] <= fb_re;
    pa[0] <= fb_addr[7:0];
    for (int i = 1; i < RD_LAT; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
    if (fb_we) mem[fb_addr[7:0]] <= fb_wdata;
  end

  always @(negedge clk) begin
    wr_t e;
    checks++;
    if (fb_re === 1'b1 && fb_we === 1'b1) begin
      errors++;
      $display("FAIL re_we_overlap: cycle %0d fb_re and fb_we both 1, required not both", cyc);
    end
    if (fb_re === 1'b1) re_count++;
    if (frame_done === 1'b1) done_count++;
    if (fb_we === 1'b1) begin
      we_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: cycle %0d addr %0d data %h, required no write", cyc, fb_addr, fb_wdata);
      end else begin
        e = exp_q.pop_front();
        if (fb_addr !== e.addr || fb_wdata !== e.data) begin
          errors++;
          $display("FAIL sb_write: cycle %0d got addr %0d data %h, required addr %0d data %h",
                   cyc, fb_addr, fb_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] addr, input logic [23:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [ADDR_W-1:0] addr, input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b, input logic [7:0] a, input logic last, output int acc);
    acc      = -1;
    in_valid = 1'b1;
    in_pixel = addr;
    in_r = r; in_g = g; in_b = b; in_a = a;
    in_last  = last;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        acc = cyc;
        break;
      end
    end
    checks++;
    if (acc < 0) begin
      errors++;
      $display("FAIL accept_timeout: addr %0d not accepted within 50 cycles, required acceptance", addr);
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    in_valid = 1'b0; in_pixel = '0; in_last = 1'b0;
    in_r = '0; in_g = '0; in_b = '0; in_a = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || fb_re !== 1'b0 || fb_we !== 1'b0 || frame_done !== 1'b0 ||
        bl_pixel_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready %b re %b we %b done %b blr %b, required 1 0 0 0 0",
               in_ready, fb_re, fb_we, frame_done, bl_pixel_ready);
    end
    checks++;
    if (fb_addr !== '0 || frame_px_count !== '0 || fb_wdata !== '0) begin
      errors++;
      $display("FAIL reset_data: addr %0d count %0d wdata %h, required 0 0 0",
               fb_addr, frame_px_count, fb_wdata);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_blend;
    int a;
    push_exp(17'd100, {8'd100, 8'd0, 8'd25});
    send(17'd100, 8'd200, 8'd0, 8'd50, 8'd128, 1'b0, a);
    @(negedge clk);
    checks++;
    if (fb_re !== 1'b1 || bl_pixel_ready !== 1'b1 || cyc != a + 1) begin
      errors++;
      $display("FAIL blend_read: cycle %0d re %b blr %b, required re 1 blr 1 at %0d", cyc, fb_re, bl_pixel_ready, a + 1);
    end
    checks++;
    if (bl_r !== 8'd200 || bl_a !== 8'd128) begin
      errors++;
      $display("FAIL blend_bl_regs: bl_r %0d bl_a %0d, required 200 128", bl_r, bl_a);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (fb_we !== 1'b0 || fb_re !== 1'b0) begin
        errors++;
        $display("FAIL blend_early: cycle %0d re %b we %b, required 0 0", cyc, fb_re, fb_we);
      end
    end
    @(negedge clk);
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 17'd100 || fb_wdata !== 24'h640019 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL blend_write: cycle %0d we %b addr %0d wdata %h ready %b, required 1 100 640019 0",
               cyc, fb_we, fb_addr, fb_wdata, in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || cyc != a + 5) begin
      errors++;
      $display("FAIL blend_ready_back: cycle %0d ready %b, required 1 at %0d", cyc, in_ready, a + 5);
    end
    step();
  endtask

  task automatic test_opaque;
    int a;
    int re0;
    re0 = re_count;
    push_exp(17'd7, 24'h010203);
    send(17'd7, 8'd1, 8'd2, 8'd3, 8'd255, 1'b0, a);
    @(negedge clk);
    checks++;
    if (fb_we !== 1'b1 || fb_re !== 1'b0 || fb_wdata !== 24'h010203 || fb_addr !== 17'd7) begin
      errors++;
      $display("FAIL opaque_write: we %b re %b wdata %h addr %0d, required 1 0 010203 7",
               fb_we, fb_re, fb_wdata, fb_addr);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || re_count != re0) begin
      errors++;
      $display("FAIL opaque_ready: ready %b reads %0d, required 1 and %0d", in_ready, re_count, re0);
    end
    step();
  endtask

  task automatic test_transparent_stream;
    int re0, we0, first;
    re0 = re_count;
    we0 = we_count;
    first = -1;
    in_valid = 1'b1;
    in_a = 8'd0;
    in_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_pixel = ADDR_W'(50 + i);
      in_r = 8'(i); in_g = 8'(i + 1); in_b = 8'(i + 2);
      @(negedge clk);
      if (i == 0) first = cyc;
      checks++;
      if (in_ready !== 1'b1 || cyc != first + i) begin
        errors++;
        $display("FAIL transp_accept_%0d: ready %b cycle %0d, required 1 at %0d", i, in_ready, cyc, first + i);
      end
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    checks++;
    if (re_count != re0 || we_count != we0) begin
      errors++;
      $display("FAIL transp_no_mem: reads %0d writes %0d, required %0d %0d", re_count, we_count, re0, we0);
    end
  endtask

  task automatic test_frame_end;
    int a, d0, w0;
    logic [23:0] dst;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    d0 = done_count;
    w0 = we_count;
    dst = mem[7];
    push_exp(17'd7, {blend(8'd10, dst[23:16], 8'd128), blend(8'd20, dst[15:8], 8'd128),
                     blend(8'd30, dst[7:0], 8'd128)});
    send(17'd7, 8'd10, 8'd20, 8'd30, 8'd128, 1'b0, a);
    push_exp(17'd21, 24'h090807);
    send(17'd21, 8'd9, 8'd8, 8'd7, 8'd255, 1'b0, a);
    send(17'd22, 8'd1, 8'd1, 8'd1, 8'd0, 1'b1, a);
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1 || cyc != a + 1) begin
      errors++;
      $display("FAIL frame_done_pulse: cycle %0d done %b, required 1 at %0d", cyc, frame_done, a + 1);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0 || frame_px_count !== 17'd2) begin
      errors++;
      $display("FAIL frame_count: done %b count %0d, required 0 2", frame_done, frame_px_count);
    end
    checks++;
    if (done_count != d0 + 1 || we_count != w0 + 2) begin
      errors++;
      $display("FAIL frame_totals: dones %0d writes %0d, required %0d %0d", done_count, we_count, d0 + 1, w0 + 2);
    end
    step();

    // Second frame: a single written pixel; count must restart from zero.
    push_exp(17'd30, 24'h040506);
    send(17'd30, 8'd4, 8'd5, 8'd6, 8'd255, 1'b1, a);
    @(negedge clk);
    checks++;
    if (fb_we !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL frame2_write: we %b done %b, required 1 0", fb_we, frame_done);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1 || cyc != a + 2) begin
      errors++;
      $display("FAIL frame2_done: cycle %0d done %b, required 1 at %0d", cyc, frame_done, a + 2);
    end
    @(negedge clk);
    checks++;
    if (frame_px_count !== 17'd1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL frame2_count: count %0d done %b, required 1 0", frame_px_count, frame_done);
    end
    step();
  endtask

  task automatic test_reset_mid_wait;
    int a, w0;
    w0 = we_count;
    send(17'd40, 8'd50, 8'd60, 8'd70, 8'd100, 1'b0, a);
    @(negedge clk);
    checks++;
    if (fb_re !== 1'b1) begin
      errors++;
      $display("FAIL midwait_read: re %b, required 1", fb_re);
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || fb_we !== 1'b0 || frame_px_count !== '0 || fb_addr !== '0) begin
      errors++;
      $display("FAIL midwait_reset: ready %b we %b count %0d addr %0d, required 1 0 0 0",
               in_ready, fb_we, frame_px_count, fb_addr);
    end
    step();
    reset = 1'b1;
    repeat (8) step();
    checks++;
    if (we_count != w0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midwait_no_write: writes %0d ready %b, required %0d 1", we_count, in_ready, w0);
    end
  endtask

  initial begin
    test_reset();
    test_blend();
    test_opaque();
    test_transparent_stream();
    test_frame_end();
    test_reset_mid_wait();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected writes outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
